// File: rtl/pool_max_ctrl.sv
// Sequencer for a max-pooling PE: counts beats per window and windows per job,
// and gates PE valid/clear and the result handshake. Optional stall counter: POOL_MAX_CTRL_PERF_EN.
module pool_max_ctrl #(
  parameter int WIN_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_win_size,
  input  logic [CNT_W-1:0] i_num_win,
  input  logic             i_in_vld,
  output logic             o_in_rdy,
  output logic             o_pe_vld,
  output logic             o_pe_en,
  output logic             o_pe_clear,
  output logic             o_res_vld,
  input  logic             i_res_rdy,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_win_idx
`ifdef POOL_MAX_CTRL_PERF_EN
  ,
  output logic [31:0]      o_stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] bcnt_q, bcnt_d;
  logic [WIN_W-1:0] win_size_q, win_size_d;
  logic [CNT_W-1:0] win_idx_q, win_idx_d;
  logic [CNT_W-1:0] num_win_q, num_win_d;
  logic             run, last, last_win, accept, start_ok;

  // NOTE: every signal gets a default before any branch, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    win_idx_d  = win_idx_q;
    win_size_d = win_size_q;
    num_win_d  = num_win_q;

    run      = (state_q == ST_RUN);
    last     = (bcnt_q == win_size_q - WIN_W'(1));
    last_win = (win_idx_q == num_win_q - CNT_W'(1));
    start_ok = (state_q == ST_IDLE) && i_start && !i_abort;

    // The result handshake rides on the final beat, so a stalled consumer blocks that beat.
    o_in_rdy   = run && !i_abort && (!last || i_res_rdy);
    accept     = i_in_vld && o_in_rdy;
    o_pe_vld   = accept;
    o_pe_en    = run;
    o_pe_clear = !run || (accept && last) || (run && i_abort);
    o_res_vld  = run && i_in_vld && last;
    o_busy     = run;
    o_done     = (state_q == ST_DONE);
    o_win_idx  = win_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          win_size_d = i_win_size;
          num_win_d  = i_num_win;
          bcnt_d     = '0;
          win_idx_d  = '0;
          state_d    = (i_win_size != '0 && i_num_win != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (accept) begin
          if (last) begin
            bcnt_d    = '0;
            win_idx_d = win_idx_q + CNT_W'(1);
            if (last_win) state_d = ST_DONE;
          end else begin
            bcnt_d = bcnt_q + WIN_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      win_idx_q  <= '0;
      win_size_q <= '0;
      num_win_q  <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      win_idx_q  <= win_idx_d;
      win_size_q <= win_size_d;
      num_win_q  <= num_win_d;
    end
  end

`ifdef POOL_MAX_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if (run && i_in_vld && !o_in_rdy && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pool_max_ctrl.sv
// Directed self-checking bench for pool_max_ctrl: full jobs, result back-pressure,
// single-beat windows, empty jobs, abort and asynchronous reset.
module tb_pool_max_ctrl;

  localparam int WIN_W = 5;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start, i_abort, i_in_vld, i_res_rdy;
  logic [WIN_W-1:0] i_win_size;
  logic [CNT_W-1:0] i_num_win;
  logic             o_in_rdy, o_pe_vld, o_pe_en, o_pe_clear, o_res_vld, o_busy, o_done;
  logic [CNT_W-1:0] o_win_idx;
`ifdef POOL_MAX_CTRL_PERF_EN
  logic [31:0]      o_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pool_max_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_win_size (i_win_size),
    .i_num_win  (i_num_win),
    .i_in_vld   (i_in_vld),
    .o_in_rdy   (o_in_rdy),
    .o_pe_vld   (o_pe_vld),
    .o_pe_en    (o_pe_en),
    .o_pe_clear (o_pe_clear),
    .o_res_vld  (o_res_vld),
    .i_res_rdy  (i_res_rdy),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_win_idx  (o_win_idx)
`ifdef POOL_MAX_CTRL_PERF_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drive a start pulse for one cycle; returns 1 unit after the edge that sampled it.
  task automatic start_job(input int ws, input int nw);
    i_win_size = WIN_W'(ws);
    i_num_win  = CNT_W'(nw);
    i_start    = 1'b1;
    step();
    i_start    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  o_busy,     0);
    check({tag, "_done"},  o_done,     0);
    check({tag, "_rdy"},   o_in_rdy,   0);
    check({tag, "_pevld"}, o_pe_vld,   0);
    check({tag, "_peen"},  o_pe_en,    0);
    check({tag, "_pecl"},  o_pe_clear, 1);
    check({tag, "_resv"},  o_res_vld,  0);
    check({tag, "_widx"},  o_win_idx,  0);
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_in_vld   = 1'b1;
    i_res_rdy  = 1'b1;
    i_win_size = '0;
    i_num_win  = '0;

    // Reset state, with upstream and downstream both eager.
    #3;
    check_reset_outputs("rst");
`ifdef POOL_MAX_CTRL_PERF_EN
    check("rst_stall", o_stall_cnt, 0);
`endif
    #10 i_rst_n = 1'b1;
    step();

    // Four-beat windows, three windows, no back-pressure.
    start_job(4, 3);
    for (int k = 1; k <= 12; k++) begin
      #1;
      check($sformatf("t1_rdy%0d", k),  o_in_rdy,   1);
      check($sformatf("t1_pev%0d", k),  o_pe_vld,   1);
      check($sformatf("t1_res%0d", k),  o_res_vld,  (k % 4) == 0);
      check($sformatf("t1_clr%0d", k),  o_pe_clear, (k % 4) == 0);
      check($sformatf("t1_widx%0d", k), o_win_idx,  (k - 1) / 4);
      step();
    end
    #1;
    check("t1_done", o_done, 1);
    check("t1_busy", o_busy, 0);
    check("t1_rdy_done", o_in_rdy, 0);
    step();
    check("t1_done_drop", o_done, 0);

    // Result back-pressure on the final beat of a window.
    start_job(4, 2);
    for (int k = 1; k <= 3; k++) begin
      #1;
      check($sformatf("t2_rdy%0d", k), o_in_rdy, 1);
      step();
    end
    i_res_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t2_stall_rdy%0d", k), o_in_rdy,   0);
      check($sformatf("t2_stall_pev%0d", k), o_pe_vld,   0);
      check($sformatf("t2_stall_res%0d", k), o_res_vld,  1);
      check($sformatf("t2_stall_clr%0d", k), o_pe_clear, 0);
      step();
    end
`ifdef POOL_MAX_CTRL_PERF_EN
    check("t2_stall_cnt", o_stall_cnt, 3);
`endif
    i_res_rdy = 1'b1;
    #1;
    check("t2_b4_rdy", o_in_rdy,   1);
    check("t2_b4_clr", o_pe_clear, 1);
    check("t2_b4_idx", o_win_idx,  0);
    step();
    #1;
    check("t2_b5_res", o_res_vld,  0);
    check("t2_b5_clr", o_pe_clear, 0);
    check("t2_b5_idx", o_win_idx,  1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    step();

    // Single-beat windows, with an upstream gap after the second beat.
    start_job(1, 5);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t3_res%0d", k),  o_res_vld,  1);
      check($sformatf("t3_clr%0d", k),  o_pe_clear, 1);
      check($sformatf("t3_widx%0d", k), o_win_idx,  k);
      step();
      if (k == 1) begin
        i_in_vld = 1'b0;
        #1;
        check("t3_gap_pev",  o_pe_vld,  0);
        check("t3_gap_res",  o_res_vld, 0);
        check("t3_gap_busy", o_busy,    1);
        step();
        i_in_vld = 1'b1;
      end
    end
    #1;
    check("t3_done", o_done, 1);
    step();

    // Empty job: immediate done pulse and no accepts.
    start_job(4, 0);
    #1;
    check("t4_done", o_done,   1);
    check("t4_rdy",  o_in_rdy, 0);
    check("t4_busy", o_busy,   0);
    step();
    check("t4_done_drop", o_done,   0);
    check("t4_rdy_idle",  o_in_rdy, 0);

    // Abort beats start in IDLE: no job, no pulse.
    i_abort = 1'b1;
    start_job(4, 3);
    i_abort = 1'b0;
    #1;
    check("t4_abort_done", o_done, 0);
    check("t4_abort_busy", o_busy, 0);

    // Abort at window 1, beat 2.
    start_job(4, 3);
    for (int k = 0; k < 5; k++) step();
    i_abort = 1'b1;
    #1;
    check("t5_ab_rdy",  o_in_rdy,   0);
    check("t5_ab_pev",  o_pe_vld,   0);
    check("t5_ab_clr",  o_pe_clear, 1);
    check("t5_ab_widx", o_win_idx,  1);
    step();
    i_abort = 1'b0;
    #1;
    check("t5_done",     o_done,   1);
    check("t5_done_rdy", o_in_rdy, 0);
    step();
    check("t5_idle_busy", o_busy, 0);
    check("t5_idle_done", o_done, 0);
    start_job(4, 3);
    #1;
    check("t5_re_busy", o_busy,    1);
    check("t5_re_widx", o_win_idx, 0);
    check("t5_re_rdy",  o_in_rdy,  1);
    step();

    // Reset in the middle of a window, away from any clock edge.
    step();
    #2 i_rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    #10 i_rst_n = 1'b1;
    step();
    start_job(4, 2);
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("t6_res%0d", k), o_res_vld, k == 4);
      check($sformatf("t6_idx%0d", k), o_win_idx, 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
